// File: rtl/pattern_serializer_if.sv
// Host-side control/status bundle for the pattern serializer.
// Handshake: valid is a pure qualifier on waveform. It is high on every cycle
// that waveform carries a pattern bit. There is no ready and no backpressure,
// so the consumer must take one bit per clock while valid is high.
interface pattern_serializer_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              msb_first;
  logic [ADDR_W-1:0] last_addr;
  logic              waveform;
  logic              valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_addr;

  // Host / stimulus side
  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_en, msb_first, last_addr,
    input  waveform, valid, busy, done, cur_addr
  );

  // Serializer side
  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_en, msb_first, last_addr,
    output waveform, valid, busy, done, cur_addr
  );
endinterface

// File: rtl/pattern_serializer.sv
// Serial waveform generator. It replays a DEPTH x WORD_W pattern RAM one bit
// per clock, walking words 0..end. Playback can be single-shot or looping, and
// each word can be sent LSB-first or MSB-first.
module pattern_serializer #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int BIT_W  = 3
) (
  input  logic                clk,
  input  logic                clear,
  pattern_serializer_if.slave bus,
  output logic                o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [BIT_W-1:0]  r_bit;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end;
  logic              r_msb;
  logic              r_wave;
  logic              r_valid;
  logic              r_done;

  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_start_end;
  logic [BIT_W-1:0]  w_start_bit;
  logic              w_start_wave;
  logic [BIT_W-1:0]  w_run_first;
  logic              w_last_bit;
  logic              w_end_word;
  logic              w_pass_end;
  logic [ADDR_W-1:0] w_next_addr;
  logic [BIT_W-1:0]  w_next_bit;
  logic              w_next_wave;

  // The compare uses one extra bit so that DEPTH == 2**ADDR_W also works.
  assign w_wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(DEPTH));

  // Run setup, taken from the live inputs at the start edge.
  assign w_start_end  = (bus.last_addr > LAST_WORD) ? LAST_WORD : bus.last_addr;
  assign w_start_bit  = bus.msb_first ? TOP_BIT : '0;
  assign w_start_wave = r_mem[0][w_start_bit];

  // Position tracking for the current run.
  assign w_run_first = r_msb ? TOP_BIT : '0;
  assign w_last_bit  = r_msb ? (r_bit == '0) : (r_bit == TOP_BIT);
  assign w_end_word  = (r_addr == r_end);
  assign w_pass_end  = w_last_bit && w_end_word;

  // Next bit position: step within the word, or move to the next word's first bit.
  always_comb begin
    w_next_addr = r_addr;
    w_next_bit  = r_bit;
    if (w_last_bit) begin
      w_next_bit  = w_run_first;
      w_next_addr = w_end_word ? '0 : r_addr + 1'b1;
    end else if (r_msb) begin
      w_next_bit = r_bit - 1'b1;
    end else begin
      w_next_bit = r_bit + 1'b1;
    end
  end

  // Reading before the write commits means a same-edge write shows old data.
  assign w_next_wave = r_mem[w_next_addr][w_next_bit];

  // Pattern RAM write port. Clear does not reset it, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Playback FSM. All outputs are registered, and stop overrides everything in RUN.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_addr  <= '0;
      r_end   <= '0;
      r_msb   <= 1'b0;
      r_wave  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            r_state <= S_RUN;
            r_msb   <= bus.msb_first;
            r_end   <= w_start_end;
            r_bit   <= w_start_bit;
            r_addr  <= '0;
            r_wave  <= w_start_wave;
            r_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_wave  <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_bit   <= '0;
          end else if (w_pass_end && !bus.loop_en) begin
            r_state <= S_IDLE;
            r_wave  <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_bit   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_addr <= w_next_addr;
            r_bit  <= w_next_bit;
            r_wave <= w_next_wave;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.waveform = r_wave;
  assign bus.valid    = r_valid;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = r_done;
  assign bus.cur_addr = r_addr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer. Inputs are driven and outputs are
// sampled on the falling edge. The expected bit stream is built from a local
// RAM model when a run is started, and popped once per emitted bit.
module tb_pattern_serializer;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;
  localparam int BIT_W  = 3;
  localparam int EW     = ADDR_W + 1;

  logic clk;
  logic clear;
  logic dbg_state;

  pattern_serializer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) ifc ();

  pattern_serializer #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BIT_W(BIT_W)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .bus         (ifc.slave),
    .o_dbg_state (dbg_state)
  );

  logic [WORD_W-1:0] tb_mem [DEPTH];
  logic [EW-1:0]     exp_q[$];   // {cur_addr, waveform} per emitted bit
  int n_checks;
  int n_errors;

  // Clock generator
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = a;
    ifc.wr_data = d;
    @(negedge clk);
    ifc.wr_en = 1'b0;
    if (int'(a) < DEPTH) tb_mem[a] = d;
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] w,
                           input logic msb);
    for (int b = 0; b < WORD_W; b++) begin
      int idx;
      idx = msb ? (WORD_W - 1 - b) : b;
      exp_q.push_back({a, w[idx]});
    end
  endtask

  task automatic push_pass(input int end_a, input logic msb);
    for (int w = 0; w <= end_a; w++) push_word(ADDR_W'(w), tb_mem[w], msb);
  endtask

  // Leaves the bench at the sample point of cycle 1 of the run.
  task automatic start_run(input logic [ADDR_W-1:0] last, input logic msb, input logic lp);
    ifc.last_addr = last;
    ifc.msb_first = msb;
    ifc.loop_en   = lp;
    ifc.start     = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ifc.waveform, ifc.valid, ifc.busy, ifc.done, ifc.cur_addr, dbg_state} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got w=%0b v=%0b b=%0b d=%0b a=%0d st=%0b, want all 0",
               ifc.waveform, ifc.valid, ifc.busy, ifc.done, ifc.cur_addr, dbg_state);
    end
    clear = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ifc.valid, ifc.busy, ifc.done} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_after_reset: got v=%0b b=%0b d=%0b, want 000",
               ifc.valid, ifc.busy, ifc.done);
    end
  endtask

  task automatic test_lsb_single;
    logic [EW-1:0] e;
    write_word(0, 8'hCC);
    write_word(1, 8'hAA);
    push_pass(1, 1'b0);
    start_run(1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.busy, ifc.done, ifc.cur_addr, ifc.waveform} !== {3'b110, e}) begin
        n_errors++;
        $display("FAIL lsb_bit%0d: got v=%0b b=%0b d=%0b a=%0d w=%0b, want v=1 b=1 d=0 a=%0d w=%0b",
                 i, ifc.valid, ifc.busy, ifc.done, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ifc.valid, ifc.busy, ifc.done, ifc.waveform} !== 4'b0010) begin
      n_errors++;
      $display("FAIL lsb_done: got v=%0b b=%0b d=%0b w=%0b, want 0 0 1 0",
               ifc.valid, ifc.busy, ifc.done, ifc.waveform);
    end
    @(negedge clk);
    n_checks++;
    if (ifc.done !== 1'b0) begin
      n_errors++;
      $display("FAIL lsb_done_width: got done=%0b, want 0", ifc.done);
    end
  endtask

  task automatic test_msb_single;
    logic [EW-1:0] e;
    push_pass(1, 1'b1);
    start_run(1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.cur_addr, ifc.waveform} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL msb_bit%0d: got v=%0b a=%0d w=%0b, want v=1 a=%0d w=%0b",
                 i, ifc.valid, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ifc.valid, ifc.done} !== 2'b01) begin
      n_errors++;
      $display("FAIL msb_done: got v=%0b d=%0b, want v=0 d=1", ifc.valid, ifc.done);
    end
    @(negedge clk);
  endtask

  task automatic test_loop;
    logic [EW-1:0] e;
    write_word(0, 8'hF0);
    for (int p = 0; p < 5; p++) push_pass(0, 1'b0);
    start_run(0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.done, ifc.cur_addr, ifc.waveform} !== {2'b10, e}) begin
        n_errors++;
        $display("FAIL loop_bit%0d: got v=%0b d=%0b a=%0d w=%0b, want v=1 d=0 a=%0d w=%0b",
                 i, ifc.valid, ifc.done, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    push_pass(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) ifc.loop_en = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.done, ifc.cur_addr, ifc.waveform} !== {2'b10, e}) begin
        n_errors++;
        $display("FAIL loop_tail%0d: got v=%0b d=%0b a=%0d w=%0b, want v=1 d=0 a=%0d w=%0b",
                 i, ifc.valid, ifc.done, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ifc.valid, ifc.busy, ifc.done} !== 3'b001) begin
      n_errors++;
      $display("FAIL loop_done: got v=%0b b=%0b d=%0b, want 0 0 1",
               ifc.valid, ifc.busy, ifc.done);
    end
    @(negedge clk);
  endtask

  task automatic test_stop;
    logic [EW-1:0] e;
    write_word(0, 8'hCC);
    write_word(1, 8'hAA);
    push_pass(1, 1'b0);
    start_run(1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) ifc.start = 1'b1;
      if (i == 2) ifc.start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.cur_addr, ifc.waveform} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL stop_bit%0d: got v=%0b a=%0d w=%0b, want v=1 a=%0d w=%0b",
                 i, ifc.valid, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      if (i == 4) ifc.stop = 1'b1;
      @(negedge clk);
    end
    ifc.stop = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({ifc.valid, ifc.busy, ifc.done, ifc.waveform, dbg_state} !== 5'b00000) begin
      n_errors++;
      $display("FAIL stop_halt: got v=%0b b=%0b d=%0b w=%0b st=%0b, want all 0",
               ifc.valid, ifc.busy, ifc.done, ifc.waveform, dbg_state);
    end
    @(negedge clk);
    n_checks++;
    if ({ifc.busy, ifc.done} !== 2'b00) begin
      n_errors++;
      $display("FAIL stop_no_done: got b=%0b d=%0b, want 00", ifc.busy, ifc.done);
    end
    ifc.start = 1'b1;
    ifc.stop  = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    n_checks++;
    if ({ifc.valid, ifc.busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL start_stop_idle: got v=%0b b=%0b, want 00", ifc.valid, ifc.busy);
    end
  endtask

  task automatic test_clear_mid;
    logic [EW-1:0] e;
    push_pass(1, 1'b0);
    start_run(1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.cur_addr, ifc.waveform} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL clr_pre%0d: got v=%0b a=%0d w=%0b, want v=1 a=%0d w=%0b",
                 i, ifc.valid, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if ({ifc.waveform, ifc.valid, ifc.busy, ifc.done, ifc.cur_addr} !== '0) begin
      n_errors++;
      $display("FAIL clr_async: got w=%0b v=%0b b=%0b d=%0b a=%0d, want all 0",
               ifc.waveform, ifc.valid, ifc.busy, ifc.done, ifc.cur_addr);
    end
    exp_q.delete();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    push_pass(1, 1'b0);
    start_run(1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.cur_addr, ifc.waveform} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL clr_replay%0d: got v=%0b a=%0d w=%0b, want v=1 a=%0d w=%0b",
                 i, ifc.valid, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (ifc.done !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_replay_done: got done=%0b, want 1", ifc.done);
    end
    @(negedge clk);
  endtask

  task automatic test_write_collision;
    logic [EW-1:0]     e;
    logic [WORD_W-1:0] old_w;
    logic [WORD_W-1:0] new_w;
    write_word(1, 8'hAA);
    old_w = tb_mem[1];
    new_w = 8'h0F;
    push_word(0, tb_mem[0], 1'b0);
    exp_q.push_back({ADDR_W'(1), old_w[0]});
    for (int b = 1; b < WORD_W; b++) exp_q.push_back({ADDR_W'(1), new_w[b]});
    start_run(1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) ifc.wr_en = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.cur_addr, ifc.waveform} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL wr_coll_bit%0d: got v=%0b a=%0d w=%0b, want v=1 a=%0d w=%0b",
                 i, ifc.valid, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      if (i == 7) begin
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = 1;
        ifc.wr_data = new_w;
      end
      @(negedge clk);
    end
    tb_mem[1] = new_w;
    n_checks++;
    if (ifc.done !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_coll_done: got done=%0b, want 1", ifc.done);
    end
    @(negedge clk);
  endtask

  task automatic test_end_clamp;
    logic [EW-1:0] e;
    for (int w = 2; w < DEPTH; w++) write_word(ADDR_W'(w), WORD_W'($urandom_range(0, 255)));
    write_word(9, 8'h00);   // out of range: must not land in word 1
    push_pass(DEPTH - 1, 1'b0);
    start_run(15, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH * WORD_W; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.cur_addr, ifc.waveform} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL clamp_bit%0d: got v=%0b a=%0d w=%0b, want v=1 a=%0d w=%0b",
                 i, ifc.valid, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ifc.valid, ifc.busy, ifc.done} !== 3'b001) begin
      n_errors++;
      $display("FAIL clamp_done: got v=%0b b=%0b d=%0b, want 0 0 1",
               ifc.valid, ifc.busy, ifc.done);
    end
  endtask

  // Restart on the very cycle done is shown (state is already IDLE).
  task automatic test_back_to_back;
    logic [EW-1:0] e;
    push_pass(0, 1'b1);
    start_run(0, 1'b1, 1'b0);
    for (int i = 0; i < WORD_W; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ifc.valid, ifc.busy, ifc.cur_addr, ifc.waveform} !== {2'b11, e}) begin
        n_errors++;
        $display("FAIL b2b_bit%0d: got v=%0b b=%0b a=%0d w=%0b, want v=1 b=1 a=%0d w=%0b",
                 i, ifc.valid, ifc.busy, ifc.cur_addr, ifc.waveform, e[EW-1:1], e[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ifc.valid, ifc.done} !== 2'b01) begin
      n_errors++;
      $display("FAIL b2b_done: got v=%0b d=%0b, want v=0 d=1", ifc.valid, ifc.done);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks      = 0;
    n_errors      = 0;
    clear         = 1'b0;
    ifc.wr_en     = 1'b0;
    ifc.wr_addr   = '0;
    ifc.wr_data   = '0;
    ifc.start     = 1'b0;
    ifc.stop      = 1'b0;
    ifc.loop_en   = 1'b0;
    ifc.msb_first = 1'b0;
    ifc.last_addr = '0;
    for (int w = 0; w < DEPTH; w++) tb_mem[w] = '0;

    test_reset();
    test_lsb_single();
    test_msb_single();
    test_loop();
    test_stop();
    test_clear_mid();
    test_write_collision();
    test_end_clamp();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
